zle_stream_arbiter: RTL and testbench
=====================================

Name: zle_stream_arbiter

Overview:
- Shares one zero run-length encoder between N producer streams using round-robin arbitration.
- A grant switches only at a run-safe boundary: after a nonzero token, so no zero run merges across two streams.
- Sits between the N source streams and the encoder's input stream.
- Datapath is combinational pass-through; grant and control are registered.

Parameters:
- N, 4, number of requesting streams (power of 2, 2..16)
- ID_W, 2, width of grant id; equals log2(N)
- W, 3, token width; matches the encoder's input token width
- BURST, 8, tokens per grant before the arbiter may re-arbitrate (1..255)

Ports:
- clock  input  1  clock
- reset  input  1  asynchronous, active-low reset
- req_d  input  N*W  token data; stream k occupies bits [k*W +: W]
- req_v  input  N  per-stream valid
- req_b  output  N  per-stream back-pressure (1 = stall)
- enc_d  output  W  token to encoder
- enc_v  output  1  valid to encoder
- enc_b  input  1  back-pressure from encoder
- grant_id  output  ID_W  index of the currently granted stream
- busy  output  1  1 while in GRANT or DRAIN
- in_run  output  1  1 when the last token forwarded in this grant was zero

Behaviour:
- Transfer rule: a transfer occurs on a stream when v=1 and b=0 in the same cycle.
- Clock and reset: clock is `clock`; reset is `reset`, asynchronous, active-low.
- Reset values:
  - state=IDLE, rr pointer=0, grant_id=0, burst count=0, in_run=0
  - enc_v=0, req_b all 1, busy=0
  - enc_d=0 whenever no grant is active.
- States: IDLE, GRANT, DRAIN.
- IDLE:
  - All req_b=1 and enc_v=0.
  - If any req_v is set, pick the first set bit searching from the rr pointer upward, with wrap (N-1 wraps to 0).
  - Register the winner into grant_id, clear the count, and go to GRANT on the next edge.
  - Arbitration costs exactly one idle cycle. No requests: stay in IDLE.
- GRANT and DRAIN pass-through, with g = grant_id:
  - enc_d = req_d[g], enc_v = req_v[g], req_b[g] = enc_b; all other req_b = 1.
  - Latency 0, fully combinational.
- On each transfer:
  - count increments, saturating at BURST.
  - in_run <= (enc_d == 0).
- GRANT exit conditions:
  - A transfer brings the count to BURST and the token is nonzero: go to IDLE and set rr pointer to g+1 mod N.
  - A transfer brings the count to BURST and the token is zero: go to DRAIN.
- DRAIN: keep forwarding the same stream without limit. On the first nonzero transfer, go to IDLE and set rr pointer to g+1.
- Stalls: if the granted stream is not valid, or the encoder asserts enc_b, the grant holds and no other stream is serviced. There is no starvation timeout unless the optional feature is compiled in.
- Count width: 8 bits. Compare against BURST only; no wrap is possible.
- Simultaneous requests in IDLE: the rr pointer alone decides. Example: pointer=2 and req_v=4'b1011 grants stream 3.
- Reset mid-grant: the next cycle is IDLE with pointer 0. Any zero run in progress is abandoned, and the encoder is reset by the same net.
- busy = (state != IDLE).

Optional Feature:
- Macro: ZLE_ARB_IDLE_RELEASE_EN.
- When defined:
  - In GRANT only, with in_run=0 (run-safe), a counter tracks consecutive cycles with req_v[g]=0. It is 4 bits, cleared on any cycle with req_v[g]=1.
  - Reaching 15 forces a return to IDLE with pointer g+1.
  - DRAIN never releases early.
- When undefined: no such counter; the grant waits indefinitely for the granted stream.

Test Plan:
- Reset, then only req_v[1]=1 with tokens 5,5,5…: one IDLE cycle, grant_id=1, enc_d=5. After 8 transfers: IDLE for 1 cycle, then stream 1 is granted again.
- All four streams valid, all tokens nonzero, enc_b=0: grant order 0,1,2,3,0, with exactly 8 transfers per grant and 1 idle cycle between grants.
- Stream 0 sends 3,3,3,3,3,3,3,0,0,0,6: DRAIN entered after the 8th token (a zero). Stream 0 is held through 0,0,6 (11 transfers), then stream 1 is granted. in_run=1 while forwarding 0,0 and returns to 0 after 6.
- enc_b=1 for 5 cycles mid-grant: enc_v follows req_v[g], req_b[g]=1, count frozen, grant_id unchanged. Other streams' req_b stay 1.
- Assert reset during DRAIN: state=IDLE, enc_v=0, all req_b=1, grant_id=0 immediately (asynchronous). After release, stream 0 has first priority.
- With ZLE_ARB_IDLE_RELEASE_EN defined: stream 2 granted, sends a nonzero token, then drops valid for 15 cycles. It returns to IDLE, and waiting stream 3 is granted 1 cycle later. Without the macro, stream 2 is still granted after 100 idle cycles.

Source files
------------

// File: rtl/zle_stream_arbiter.sv
// Round-robin arbiter sharing one zero run-length encoder between N streams.
// Grants change only after a nonzero token so zero runs never span streams.
// Optional build macro ZLE_ARB_IDLE_RELEASE_EN: release a run-safe grant
// after 15 consecutive cycles with the granted stream idle.
module zle_stream_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned W     = 3,
  parameter int unsigned BURST = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N*W-1:0]  req_d,
  input  logic [N-1:0]    req_v,
  output logic [N-1:0]    req_b,
  output logic [W-1:0]    enc_d,
  output logic            enc_v,
  input  logic            enc_b,
  output logic [ID_W-1:0] grant_id,
  output logic            busy,
  output logic            in_run
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDLE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   rr_ptr_next;
  logic [ID_W-1:0]   grant_id_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  count_inc;
  logic              in_run_next;
  logic [W-1:0]      tok_c;
  logic              tok_v_c;
  logic              xfer_c;
  logic              found_c;
  logic [ID_W-1:0]   winner_c;
`ifdef ZLE_ARB_IDLE_RELEASE_EN
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_cnt_next;
`endif

  // Select the granted stream's token.
  always_comb begin
    tok_c = '0;
    for (int k = 0; k < N; k++) begin
      if (ID_W'(k) == grant_id) tok_c = req_d[k*W +: W];
    end
  end

  assign tok_v_c   = req_v[grant_id];
  assign xfer_c    = (state != IDLE) && tok_v_c && !enc_b;
  assign count_inc = (count == CNT_W'(BURST)) ? count : count + CNT_W'(1);

  // Round-robin search: first valid stream at or above the pointer, with wrap.
  always_comb begin
    found_c  = 1'b0;
    winner_c = rr_ptr;
    for (int i = 0; i < N; i++) begin
      if (!found_c && req_v[rr_ptr + ID_W'(i)]) begin
        found_c  = 1'b1;
        winner_c = rr_ptr + ID_W'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Grant, pointer, burst count and run tracking registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      grant_id <= '0;
      count    <= '0;
      in_run   <= 1'b0;
`ifdef ZLE_ARB_IDLE_RELEASE_EN
      idle_cnt <= '0;
`endif
    end else begin
      rr_ptr   <= rr_ptr_next;
      grant_id <= grant_id_next;
      count    <= count_next;
      in_run   <= in_run_next;
`ifdef ZLE_ARB_IDLE_RELEASE_EN
      idle_cnt <= idle_cnt_next;
`endif
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_next    = state;
    rr_ptr_next   = rr_ptr;
    grant_id_next = grant_id;
    count_next    = count;
    in_run_next   = in_run;
`ifdef ZLE_ARB_IDLE_RELEASE_EN
    idle_cnt_next = idle_cnt;
`endif
    case (state)
      IDLE: begin
        if (found_c) begin
          state_next    = GRANT;
          grant_id_next = winner_c;
          count_next    = '0;
          in_run_next   = 1'b0;
`ifdef ZLE_ARB_IDLE_RELEASE_EN
          idle_cnt_next = '0;
`endif
        end
      end
      GRANT: begin
        if (xfer_c) begin
          count_next  = count_inc;
          in_run_next = (tok_c == '0);
          if (count_inc == CNT_W'(BURST)) begin
            if (tok_c != '0) begin
              state_next  = IDLE;
              rr_ptr_next = grant_id + ID_W'(1);
            end else begin
              state_next  = DRAIN;
            end
          end
        end
`ifdef ZLE_ARB_IDLE_RELEASE_EN
        // Idle-release only while run-safe; a zero run must finish first.
        if (in_run || tok_v_c) begin
          idle_cnt_next = '0;
        end else if (idle_cnt == IDLE_W'(14)) begin
          idle_cnt_next = '0;
          state_next    = IDLE;
          rr_ptr_next   = grant_id + ID_W'(1);
        end else begin
          idle_cnt_next = idle_cnt + IDLE_W'(1);
        end
`endif
      end
      DRAIN: begin
        if (xfer_c) begin
          count_next  = count_inc;
          in_run_next = (tok_c == '0);
          if (tok_c != '0) begin
            state_next  = IDLE;
            rr_ptr_next = grant_id + ID_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Zero-latency pass-through of the granted stream; everything stalled in IDLE.
  always_comb begin
    req_b = '1;
    enc_d = '0;
    enc_v = 1'b0;
    if (state != IDLE) begin
      enc_d           = tok_c;
      enc_v           = tok_v_c;
      req_b[grant_id] = enc_b;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_zle_stream_arbiter.sv
// Directed bench for zle_stream_arbiter (N=4, W=3, BURST=8).
module tb_zle_stream_arbiter;

  logic        clock;
  logic        reset;
  logic [11:0] req_d;
  logic [3:0]  req_v;
  logic [3:0]  req_b;
  logic [2:0]  enc_d;
  logic        enc_v;
  logic        enc_b;
  logic [1:0]  grant_id;
  logic        busy;
  logic        in_run;

  int checks;
  int failures;

  logic [2:0] seq [0:10];

  zle_stream_arbiter #(.N(4), .ID_W(2), .W(3), .BURST(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .req_d    (req_d),
    .req_v    (req_v),
    .req_b    (req_b),
    .enc_d    (enc_d),
    .enc_v    (enc_v),
    .enc_b    (enc_b),
    .grant_id (grant_id),
    .busy     (busy),
    .in_run   (in_run)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_v = '0;
    req_d = '0;
    enc_b = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clock    = 1'b0;
    seq = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd6};

    // Reset values and single-requester bursts.
    do_reset();
    #1;
    chk("rst_busy",   32'(busy),     32'd0);
    chk("rst_encv",   32'(enc_v),    32'd0);
    chk("rst_reqb",   32'(req_b),    32'hF);
    chk("rst_gid",    32'(grant_id), 32'd0);
    chk("rst_encd",   32'(enc_d),    32'd0);
    chk("rst_inrun",  32'(in_run),   32'd0);
    req_d = {4{3'd5}};
    req_v = 4'b0010;
    #1;
    chk("t1_idle_encv", 32'(enc_v), 32'd0);
    chk("t1_idle_reqb", 32'(req_b), 32'hF);
    tick();
    chk("t1_busy",  32'(busy),     32'd1);
    chk("t1_gid",   32'(grant_id), 32'd1);
    chk("t1_encd",  32'(enc_d),    32'd5);
    chk("t1_encv",  32'(enc_v),    32'd1);
    chk("t1_reqb",  32'(req_b),    32'b1101);
    for (int i = 0; i < 7; i++) tick();
    chk("t1_after7_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_after8_busy", 32'(busy),  32'd0);
    chk("t1_after8_encd", 32'(enc_d), 32'd0);
    tick();
    chk("t1_regrant_busy", 32'(busy),     32'd1);
    chk("t1_regrant_gid",  32'(grant_id), 32'd1);

    // All four streams: round-robin order 0,1,2,3,0 with 8-token bursts.
    do_reset();
    req_d = {3'd4, 3'd3, 3'd2, 3'd1};
    req_v = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("t2_gid",  32'(grant_id), 32'(j % 4));
      chk("t2_encd", 32'(enc_d),    32'((j % 4) + 1));
      for (int i = 0; i < 7; i++) tick();
      chk("t2_hold", 32'(busy), 32'd1);
      tick();
      chk("t2_idle_busy", 32'(busy),  32'd0);
      chk("t2_idle_encv", 32'(enc_v), 32'd0);
    end

    // Zero at the burst boundary forces DRAIN until the next nonzero token.
    do_reset();
    req_v = 4'b0011;
    req_d = {6'd0, 3'd2, seq[0]};
    tick();
    chk("t3_gid", 32'(grant_id), 32'd0);
    for (int i = 0; i < 11; i++) begin
      req_d = {6'd0, 3'd2, seq[i]};
      #1;
      chk("t3_encd", 32'(enc_d), 32'(seq[i]));
      tick();
      if (i < 10) begin
        chk("t3_busy", 32'(busy),     32'd1);
        chk("t3_gid0", 32'(grant_id), 32'd0);
        chk("t3_inrun", 32'(in_run), (i >= 7) ? 32'd1 : 32'd0);
      end else begin
        chk("t3_end_busy",  32'(busy),   32'd0);
        chk("t3_end_inrun", 32'(in_run), 32'd0);
      end
    end
    tick();
    chk("t3_next_gid", 32'(grant_id), 32'd1);

    // Encoder back-pressure freezes the burst count and holds the grant.
    do_reset();
    req_d = 12'hFFF;
    req_v = 4'b0101;
    tick();
    chk("t4_gid", 32'(grant_id), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    enc_b = 1'b1;
    #1;
    chk("t4_encv", 32'(enc_v), 32'd1);
    chk("t4_reqb", 32'(req_b), 32'hF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stall_gid",  32'(grant_id), 32'd0);
      chk("t4_stall_reqb", 32'(req_b),    32'hF);
    end
    enc_b = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_hold_busy", 32'(busy), 32'd1);
    tick();
    chk("t4_end_busy", 32'(busy), 32'd0);
    tick();
    chk("t4_next_gid", 32'(grant_id), 32'd2);

    // Asynchronous reset in DRAIN clears grant and pointer.
    do_reset();
    req_d = 12'h001;
    req_v = 4'b0001;
    tick();
    for (int i = 0; i < 8; i++) tick();
    chk("t5_p1_busy", 32'(busy), 32'd0);
    req_d = 12'h000;
    req_v = 4'b0010;
    tick();
    chk("t5_gid1", 32'(grant_id), 32'd1);
    for (int i = 0; i < 8; i++) tick();
    chk("t5_drain_busy",  32'(busy),   32'd1);
    chk("t5_drain_inrun", 32'(in_run), 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_rst_busy",  32'(busy),     32'd0);
    chk("t5_rst_encv",  32'(enc_v),    32'd0);
    chk("t5_rst_reqb",  32'(req_b),    32'hF);
    chk("t5_rst_gid",   32'(grant_id), 32'd0);
    chk("t5_rst_inrun", 32'(in_run),   32'd0);
    reset = 1'b1;
    req_d = 12'h011;
    req_v = 4'b0011;
    tick();
    chk("t5_prio_gid", 32'(grant_id), 32'd0);

    // Granted stream goes idle after a nonzero token while stream 3 waits.
    do_reset();
    req_d = {3'd1, 3'd2, 3'd1, 3'd1};
    req_v = 4'b0100;
    tick();
    chk("t6_gid", 32'(grant_id), 32'd2);
    tick();
    req_v = 4'b1000;
`ifdef ZLE_ARB_IDLE_RELEASE_EN
    for (int i = 0; i < 14; i++) tick();
    chk("t6_hold_busy", 32'(busy), 32'd1);
    tick();
    chk("t6_release_busy", 32'(busy), 32'd0);
    tick();
    chk("t6_next_gid", 32'(grant_id), 32'd3);
`else
    for (int i = 0; i < 100; i++) tick();
    chk("t6_hold_busy", 32'(busy),     32'd1);
    chk("t6_hold_gid",  32'(grant_id), 32'd2);
    chk("t6_hold_encv", 32'(enc_v),    32'd0);
    chk("t6_hold_reqb", 32'(req_b),    32'b1011);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
